// File: rtl/ex_mul_div_unit_if.sv
// Request/response channels between the EX stage and the multi-cycle multiply/divide unit.
interface ex_mul_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_div;
    logic                  req_signed;
    logic [DATA_WIDTH-1:0] req_src1;
    logic [DATA_WIDTH-1:0] req_src2;
    logic                  flush;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_hi;
    logic [DATA_WIDTH-1:0] resp_lo;

    modport master (
        output req_valid, req_is_div, req_signed, req_src1, req_src2, flush, resp_ready,
        input  req_ready, resp_valid, resp_hi, resp_lo
    );

    modport slave (
        input  req_valid, req_is_div, req_signed, req_src1, req_src2, flush, resp_ready,
        output req_ready, resp_valid, resp_hi, resp_lo
    );
endinterface

// File: rtl/ex_mul_div_unit.sv
// Multi-cycle multiply / radix-2 restoring divide unit for the EX stage.
// Define MD_DIV_EARLY_TERM_EN to finish divides with |src1| < |src2| straight after setup.
module ex_mul_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_STAGES = 2
) (
    input logic              clock,
    input logic              reset,
    ex_mul_div_unit_if.slave bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] DIV_FIRST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [W-1:0]     res_hi_q, res_hi_d;
    logic [W-1:0]     res_lo_q, res_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;   // dividend bits shift out the top, quotient bits shift in
    logic [W-1:0]     dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             accept;
    logic             src1_neg, src2_neg;
    logic [W-1:0]     src1_mag, src2_mag;
    logic [2*W-1:0]   op1_ext, op2_ext, product;
    logic [W:0]       rem_sh;
    logic             take;
    logic [W-1:0]     rem_nxt, quo_nxt, rem_fix, quo_fix;
    logic             early_term;

    always_comb begin
        accept   = bus.req_valid && req_ready_q && !bus.flush;
        src1_neg = bus.req_signed && bus.req_src1[W-1];
        src2_neg = bus.req_signed && bus.req_src2[W-1];
        src1_mag = src1_neg ? -bus.req_src1 : bus.req_src1;
        src2_mag = src2_neg ? -bus.req_src2 : bus.req_src2;
        op1_ext  = bus.req_signed ? {{W{bus.req_src1[W-1]}}, bus.req_src1} : {{W{1'b0}}, bus.req_src1};
        op2_ext  = bus.req_signed ? {{W{bus.req_src2[W-1]}}, bus.req_src2} : {{W{1'b0}}, bus.req_src2};
        product  = op1_ext * op2_ext;

        // remainder stays below the divisor, so the difference always fits in W bits
        rem_sh  = {rem_q, quo_q[W-1]};
        take    = rem_sh >= {1'b0, dvs_q};
        rem_nxt = take ? (rem_sh[W-1:0] - dvs_q) : rem_sh[W-1:0];
        quo_nxt = {quo_q[W-2:0], take};
        rem_fix = rneg_q ? -rem_nxt : rem_nxt;
        quo_fix = (dvs_q == '0) ? '1 : (qneg_q ? -quo_nxt : quo_nxt);
`ifdef MD_DIV_EARLY_TERM_EN
        early_term = (cnt_q == DIV_FIRST) && (quo_q < dvs_q);
`else
        early_term = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        res_hi_d     = res_hi_q;
        res_lo_d     = res_lo_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        qneg_d       = qneg_q;
        rneg_d       = rneg_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    if (bus.req_is_div) begin
                        state_d = S_DIV;
                        cnt_d   = DIV_FIRST;
                        rem_d   = '0;
                        quo_d   = src1_mag;
                        dvs_d   = src2_mag;
                        qneg_d  = src1_neg ^ src2_neg;
                        rneg_d  = src1_neg;
                    end else begin
                        res_hi_d = product[2*W-1:W];
                        res_lo_d = product[W-1:0];
                        if (MUL_STAGES <= 1) begin
                            state_d      = S_DONE;
                            resp_valid_d = 1'b1;
                        end else begin
                            state_d = S_MUL;
                            cnt_d   = CNT_W'(MUL_STAGES - 2);
                        end
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                if (early_term) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    cnt_d        = '0;
                    res_lo_d     = '0;
                    res_hi_d     = rneg_q ? -quo_q : quo_q;
                end else if (cnt_q == '0) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    res_lo_d     = quo_fix;
                    res_hi_d     = rem_fix;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
                end
            end
            S_DONE: begin
                if (bus.resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase

        if (bus.flush) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
            req_ready_d  = 1'b1;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            res_hi_q     <= '0;
            res_lo_q     <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            res_hi_q     <= res_hi_d;
            res_lo_q     <= res_lo_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
            qneg_q       <= qneg_d;
            rneg_q       <= rneg_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hi    = res_hi_q;
    assign bus.resp_lo    = res_lo_q;
endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Self-checking bench for ex_mul_div_unit: directed corner cases plus random operations
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_mul_div_unit;
    localparam int DW = 32;
    localparam int MS = 2;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ex_mul_div_unit_if #(.DATA_WIDTH(DW)) bus ();
    ex_mul_div_unit #(.DATA_WIDTH(DW), .MUL_STAGES(MS)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {hi, lo} from plain arithmetic
    function automatic logic [63:0] model(input bit is_div, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        logic [31:0] q, r;
        if (!is_div) begin
            pa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
            pb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
            return pa * pb;
        end
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int exp_lat(input bit is_div, input bit sgn,
                                   input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (!is_div) return MS;
`ifdef MD_DIV_EARLY_TERM_EN
        if (b != 32'd0 && ma < mb) return 2;
`endif
        if (ma == 32'd0 && mb == 32'd0) return DW + 1;
        return DW + 1;
    endfunction

    task automatic run_op(input string tag, input bit is_div, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] exp;
        logic [63:0] held;
        int lat;
        bit ready_low;
        bit stable;
        exp = model(is_div, sgn, a, b);
        @(negedge clock);
        check({tag, "_req_ready"}, bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_is_div = is_div;
        bus.req_signed = sgn;
        bus.req_src1   = a;
        bus.req_src2   = b;
        bus.resp_ready = (hold == 0);
        @(posedge clock);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_is_div = 1'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_src1   = $urandom;
        bus.req_src2   = $urandom;
        lat = 0;
        ready_low = 1'b1;
        while (lat < 100) begin
            @(negedge clock);
            lat++;
            if (bus.req_ready !== 1'b0) ready_low = 1'b0;
            if (bus.resp_valid === 1'b1) break;
        end
        check({tag, "_latency"}, lat, exp_lat(is_div, sgn, a, b));
        check({tag, "_busy"}, ready_low, 1);
        check({tag, "_result"}, {bus.resp_hi, bus.resp_lo}, exp);
        if (hold > 0) begin
            held = {bus.resp_hi, bus.resp_lo};
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clock);
                if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                    {bus.resp_hi, bus.resp_lo} !== held) stable = 1'b0;
            end
            check({tag, "_hold"}, stable, 1);
            bus.resp_ready = 1'b1;
        end
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clock);
        check({tag, "_valid_drop"}, bus.resp_valid, 0);
        check({tag, "_ready_back"}, bus.req_ready, 1);
    endtask

    initial begin
        bit seen;
        bit rdy;
        logic [31:0] a, b;
        bit sgn, is_div;
        bus.req_valid  = 1'b0;
        bus.req_is_div = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp", {bus.resp_hi, bus.resp_lo}, 64'd0);
        reset = 1'b0;

        run_op("smul_m3x5", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 0);
        run_op("umul_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op("sdiv_m7d2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("sdiv_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("udiv_by0", 1'b1, 1'b0, 32'd100, 32'd0, 0);
        run_op("sdiv_neg_by0", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd0, 2);
        run_op("backpressure", 1'b1, 1'b0, 32'd1000, 32'd7, 5);
        run_op("sdiv_3d10", 1'b1, 1'b1, 32'd3, 32'd10, 0);
        run_op("sdiv_m3d10", 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd10, 1);

        // flush in the middle of a divide, with a competing request in the flush cycle
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_is_div = 1'b1;
        bus.req_signed = 1'b0;
        bus.req_src1   = 32'd5000;
        bus.req_src2   = 32'd3;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clock);
        bus.flush      = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_is_div = 1'b0;
        @(posedge clock);
        #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("flush_ready", bus.req_ready, 1);
        check("flush_valid", bus.resp_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.resp_valid !== 1'b0) seen = 1'b1;
        end
        check("flush_no_resp", seen, 0);

        // flush in IDLE masks the accept
        bus.req_valid  = 1'b1;
        bus.req_is_div = 1'b0;
        bus.req_src1   = 32'd9;
        bus.req_src2   = 32'd9;
        bus.flush      = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        seen = 1'b0;
        rdy  = 1'b1;
        repeat (MS + 3) begin
            @(negedge clock);
            if (bus.resp_valid !== 1'b0) seen = 1'b1;
            if (bus.req_ready !== 1'b1) rdy = 1'b0;
        end
        check("flush_mask_resp", seen, 0);
        check("flush_mask_ready", rdy, 1);

        run_op("mul_after_flush", 1'b0, 1'b1, 32'h0001_2345, 32'hFFFF_0010, 0);

        // reset mid-divide clears the result registers
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_is_div = 1'b1;
        bus.req_src1   = 32'd123;
        bus.req_src2   = 32'd4;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_ready", bus.req_ready, 1);
        check("midrst_valid", bus.resp_valid, 0);
        check("midrst_resp", {bus.resp_hi, bus.resp_lo}, 64'd0);

        for (int i = 0; i < 24; i++) begin
            is_div = 1'($urandom);
            sgn    = 1'($urandom);
            a      = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 20);
                1:       b = -$urandom_range(1, 20);
                2:       b = 32'd0;
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), is_div, sgn, a, b, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
